// File: rtl/enc40to16_scan.sv
// Priority-scan encoder: accepts a 40-bit request vector and streams the set-bit indices in ascending order.
// Optional feature: define ZERO_FLAG_EN to emit a single out_none beat for an all-zero vector.
module enc40to16_scan (
   input  logic        clk,
   input  logic        rst,
   input  logic [39:0] in_vec,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] out_index,
   output logic [5:0]  out_seq,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        out_none
);

   localparam int unsigned VEC_W = 40;
   localparam int unsigned IDX_W = 6;
   localparam int unsigned OUT_W = 16;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SCAN = 1'b1;

   logic [0:0]       state, state_nxt;
   logic [VEC_W-1:0] pending, pending_nxt, pending_clr;
   logic [IDX_W-1:0] seq_r, seq_nxt;
   logic [IDX_W-1:0] idx_r, idx_nxt;
   logic             last_r, last_nxt;
   logic             valid_r, valid_nxt;
   logic             ready_r, ready_nxt;
`ifdef ZERO_FLAG_EN
   logic             none_r, none_nxt;
`endif

   function automatic logic [IDX_W-1:0] lowest_set(input logic [VEC_W-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = VEC_W - 1; i >= 0; i--) begin
         if (v[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

   function automatic logic single_bit(input logic [VEC_W-1:0] v);
      return (v != '0) && ((v & (v - VEC_W'(1))) == '0);
   endfunction

   assign pending_clr = pending & ~(VEC_W'(1) << idx_r);

   // Next-state and next-output logic; beat fields are precomputed so outputs stay registered
   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      seq_nxt     = seq_r;
      idx_nxt     = idx_r;
      last_nxt    = last_r;
`ifdef ZERO_FLAG_EN
      none_nxt    = none_r;
`endif
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               pending_nxt = in_vec;
               seq_nxt     = '0;
               idx_nxt     = lowest_set(in_vec);
               last_nxt    = single_bit(in_vec);
               if (in_vec != '0) begin
                  state_nxt = S_SCAN;
`ifdef ZERO_FLAG_EN
                  none_nxt  = 1'b0;
               end else begin
                  state_nxt = S_SCAN;
                  last_nxt  = 1'b1;
                  none_nxt  = 1'b1;
`endif
               end
            end
         end
         default: begin
            if (out_ready) begin
               pending_nxt = pending_clr;
`ifdef ZERO_FLAG_EN
               none_nxt    = 1'b0;
`endif
               if (last_r) begin
                  state_nxt = S_IDLE;
                  seq_nxt   = '0;
                  idx_nxt   = '0;
                  last_nxt  = 1'b0;
               end else begin
                  seq_nxt  = IDX_W'(seq_r + IDX_W'(1));
                  idx_nxt  = lowest_set(pending_clr);
                  last_nxt = single_bit(pending_clr);
               end
            end
         end
      endcase
      valid_nxt = (state_nxt == S_SCAN);
      ready_nxt = (state_nxt == S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         pending <= '0;
         seq_r   <= '0;
         idx_r   <= '0;
         last_r  <= 1'b0;
         valid_r <= 1'b0;
         ready_r <= 1'b1;
`ifdef ZERO_FLAG_EN
         none_r  <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         pending <= pending_nxt;
         seq_r   <= seq_nxt;
         idx_r   <= idx_nxt;
         last_r  <= last_nxt;
         valid_r <= valid_nxt;
         ready_r <= ready_nxt;
`ifdef ZERO_FLAG_EN
         none_r  <= none_nxt;
`endif
      end
   end

   assign in_ready  = ready_r;
   assign out_valid = valid_r;
   assign out_index = {(OUT_W - IDX_W)'(0), idx_r};
   assign out_seq   = seq_r;
   assign out_last  = last_r;
`ifdef ZERO_FLAG_EN
   assign out_none  = none_r;
`else
   assign out_none  = 1'b0;
`endif

endmodule

// File: tb/tb_enc40to16_scan.sv
// Directed and scoreboard-checked bench for enc40to16_scan.
module tb_enc40to16_scan;

   logic        clk;
   logic        rst;
   logic [39:0] in_vec;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_index;
   logic [5:0]  out_seq;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        out_none;

   int checks = 0;
   int errors = 0;

   enc40to16_scan dut (
      .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready),
      .out_index(out_index), .out_seq(out_seq), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .out_none(out_none)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_vec = '0; in_valid = 1'b0; out_ready = 1'b0;
      tick(); tick();
      checks++;
      if ({in_ready, out_valid, out_index, out_seq, out_last, out_none} !== {1'b1, 1'b0, 16'd0, 6'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: ready=%b valid=%b idx=%0d seq=%0d last=%b none=%b, need 1 0 0 0 0 0",
                  in_ready, out_valid, out_index, out_seq, out_last, out_none);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      in_vec = 40'h00_0000_0001; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, in_ready, out_index, out_seq, out_last, out_none} !== {1'b1, 1'b0, 16'd0, 6'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL single_beat: valid=%b ready=%b idx=%0d seq=%0d last=%b none=%b, need 1 0 0 0 1 0",
                  out_valid, in_ready, out_index, out_seq, out_last, out_none);
      end
      tick();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL single_done: valid=%b ready=%b, need 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_multi();
      logic [5:0] exp_idx [3];
      exp_idx[0] = 6'd2; exp_idx[1] = 6'd5; exp_idx[2] = 6'd39;
      in_vec = 40'h80_0000_0024; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({out_valid, out_index, out_seq, out_last} !== {1'b1, 10'd0, exp_idx[i], 6'(i), 1'(i == 2)}) begin
            errors++;
            $display("FAIL multi_beat%0d: valid=%b idx=%0d seq=%0d last=%b, need 1 %0d %0d %0d",
                     i, out_valid, out_index, out_seq, out_last, exp_idx[i], i, i == 2);
         end
         tick();
      end
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL multi_done: valid=%b ready=%b, need 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_stall();
      in_vec = 40'h00_0000_0300; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({out_valid, out_index, out_seq, out_last} !== {1'b1, 16'd8, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold%0d: valid=%b idx=%0d seq=%0d last=%b, need 1 8 0 0",
                     i, out_valid, out_index, out_seq, out_last);
         end
         tick();
      end
      out_ready = 1'b1;
      checks++;
      if ({out_valid, out_index, out_seq, out_last} !== {1'b1, 16'd8, 6'd0, 1'b0}) begin
         errors++;
         $display("FAIL stall_beat0: valid=%b idx=%0d seq=%0d last=%b, need 1 8 0 0",
                  out_valid, out_index, out_seq, out_last);
      end
      tick();
      checks++;
      if ({out_valid, out_index, out_seq, out_last} !== {1'b1, 16'd9, 6'd1, 1'b1}) begin
         errors++;
         $display("FAIL stall_beat1: valid=%b idx=%0d seq=%0d last=%b, need 1 9 1 1",
                  out_valid, out_index, out_seq, out_last);
      end
      tick();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL stall_done: valid=%b ready=%b, need 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      int stray;
      in_vec = 40'hFF_FFFF_FFFF; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if ({out_valid, out_index, out_seq} !== {1'b1, 16'd4, 6'd4}) begin
         errors++;
         $display("FAIL mid_pre_reset: valid=%b idx=%0d seq=%0d, need 1 4 4", out_valid, out_index, out_seq);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({in_ready, out_valid, out_index, out_seq, out_last, out_none} !== {1'b1, 1'b0, 16'd0, 6'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL mid_async_reset: ready=%b valid=%b idx=%0d seq=%0d last=%b none=%b, need 1 0 0 0 0 0",
                  in_ready, out_valid, out_index, out_seq, out_last, out_none);
      end
      #2;
      rst = 1'b0;
      stray = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid !== 1'b0) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL mid_no_stray: beats after reset=%0d, need 0", stray);
      end
   endtask

   task automatic test_accept_after_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      in_vec = 40'h00_0000_0010; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_index, out_seq, out_last} !== {1'b1, 16'd4, 6'd0, 1'b1}) begin
         errors++;
         $display("FAIL first_edge_accept: valid=%b idx=%0d seq=%0d last=%b, need 1 4 0 1",
                  out_valid, out_index, out_seq, out_last);
      end
      tick();
   endtask

   task automatic test_zero();
      in_vec = '0; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
`ifdef ZERO_FLAG_EN
      checks++;
      if ({out_valid, out_index, out_seq, out_last, out_none} !== {1'b1, 16'd0, 6'd0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL zero_beat: valid=%b idx=%0d seq=%0d last=%b none=%b, need 1 0 0 1 1",
                  out_valid, out_index, out_seq, out_last, out_none);
      end
      tick();
      checks++;
      if ({out_valid, in_ready, out_none} !== 3'b010) begin
         errors++;
         $display("FAIL zero_done: valid=%b ready=%b none=%b, need 0 1 0", out_valid, in_ready, out_none);
      end
`else
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({out_valid, in_ready, out_none} !== 3'b010) begin
            errors++;
            $display("FAIL zero_dropped%0d: valid=%b ready=%b none=%b, need 0 1 0", i, out_valid, in_ready, out_none);
         end
         tick();
      end
`endif
   endtask

   task automatic test_random();
      int q[$];
      int exp_e, obs_e, n;
      logic [39:0] v;
      in_valid = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         v = {8'($urandom), 32'($urandom)} & {8'($urandom), 32'($urandom)};
         if (v == '0) v[$urandom_range(39, 0)] = 1'b1;
         in_vec = v;
         out_ready = 1'($urandom_range(3, 0) != 0);
         if (in_ready === 1'b1) begin
            n = 0;
            for (int b = 0; b < 40; b++) if (v[b]) n++;
            exp_e = 0;
            for (int b = 0; b < 40; b++) begin
               if (v[b]) begin
                  q.push_back(((exp_e == n - 1) ? 4096 : 0) + (exp_e << 6) + b);
                  exp_e++;
               end
            end
         end
         if (out_valid === 1'b1 && out_ready) begin
            obs_e = (int'(out_last) << 12) + (int'(out_seq) << 6) + int'(out_index);
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rand_extra_beat: idx=%0d seq=%0d last=%b, need no beat", out_index, out_seq, out_last);
            end else begin
               exp_e = q.pop_front();
               if (obs_e != exp_e || out_index[15:6] != 10'd0) begin
                  errors++;
                  $display("FAIL rand_beat: idx=%0d seq=%0d last=%b, need idx=%0d seq=%0d last=%0d",
                           out_index, out_seq, out_last, exp_e % 64, (exp_e / 64) % 64, exp_e / 4096);
               end
            end
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 100 && out_valid === 1'b1; cyc++) begin
         obs_e = (int'(out_last) << 12) + (int'(out_seq) << 6) + int'(out_index);
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL rand_drain_extra: idx=%0d, need no beat", out_index);
         end else begin
            exp_e = q.pop_front();
            if (obs_e != exp_e) begin
               errors++;
               $display("FAIL rand_drain_beat: idx=%0d seq=%0d last=%b, need idx=%0d seq=%0d last=%0d",
                        out_index, out_seq, out_last, exp_e % 64, (exp_e / 64) % 64, exp_e / 4096);
            end
         end
         tick();
      end
      checks++;
      if (q.size() != 0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rand_lost_beats: remaining=%0d valid=%b, need 0 0", q.size(), out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_stall();
      test_reset_mid();
      test_accept_after_reset();
      test_zero();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/enc40to16_scan.md
ENC40TO16_SCAN -- requirements
Module: enc40to16_scan

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port in_vec, input, 40 bits: request vector; bit k set means index k is requested.
REQ-004 SHALL have port in_valid, input, 1 bit: in_vec is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts in_vec this cycle.
REQ-006 SHALL have port out_index, output, 16 bits: binary index 0..39, bits [15:6] always 0.
REQ-007 SHALL have port out_seq, output, 6 bits: position of the current beat within the current vector, starting at 0.
REQ-008 SHALL have port out_valid, output, 1 bit: out_index, out_seq and out_last are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the beat.
REQ-010 SHALL have port out_last, output, 1 bit: the current beat is the final beat of the vector.
REQ-011 SHALL have port out_none, output, 1 bit: the beat reports an all-zero vector (ZERO_FLAG_EN only; tied 0 otherwise).

Function
REQ-012 SHALL implement two states: IDLE and SCAN.
REQ-013 IDLE SHALL drive in_ready=1 and out_valid=0; SCAN SHALL drive in_ready=0 and out_valid=1.
REQ-014 An accept (in_valid && in_ready) SHALL latch in_vec into a 40-bit pending register and clear the sequence counter.
  - On accept of a nonzero vector, the next state SHALL be SCAN.
REQ-015 In SCAN, out_index SHALL be the lowest set bit position of the pending register.
  - This SHALL give a first-beat latency of exactly 1 cycle from accept.
REQ-016 In SCAN, out_last SHALL be 1 when exactly one bit remains set in the pending register.
REQ-017 When out_valid && out_ready, the block SHALL clear the reported bit and increment out_seq.
  - If out_last=1, the next state SHALL be IDLE.
REQ-018 When out_valid && !out_ready, out_index, out_seq, out_last and the pending register SHALL hold unchanged (stall).
REQ-019 Beats SHALL be emitted in strictly ascending index order, one per handshake.
  - A vector with n set bits SHALL produce exactly n beats, with out_seq running 0..n-1.
REQ-020 A back-to-back vector SHALL NOT be accepted in the cycle of the last handshake.
  - in_ready SHALL rise in the following cycle (IDLE).
REQ-021 in_vec bit 39 SHALL map to index 39.
  - No input value SHALL produce out_index>39.
REQ-022 All outputs SHALL be driven from registers or from the state and pending register only.
  - There SHALL be no combinational path from in_vec to any output.

Reset
REQ-023 Asserting rst SHALL immediately force the following, independent of clk:
  - state=IDLE, pending register=0, out_seq=0, out_index=0, out_last=0, out_valid=0, out_none=0, in_ready=1.
REQ-024 rst asserted mid-SCAN SHALL discard all remaining pending bits; no beat of that vector SHALL appear after rst is released.
REQ-025 An accept SHALL be possible on the first rising clk edge after rst deasserts.

Configuration
REQ-026 The macro ZERO_FLAG_EN SHALL select how an all-zero accepted vector is handled.
REQ-027 With ZERO_FLAG_EN defined, an all-zero accepted vector SHALL enter SCAN.
  - It SHALL emit exactly one beat with out_index=0, out_seq=0, out_last=1 and out_none=1.
  - out_none SHALL be 0 on every other beat.
REQ-028 With ZERO_FLAG_EN undefined, an all-zero accepted vector SHALL be dropped: the state stays IDLE, no beat is emitted, and out_none stays constant 0.

Verification
REQ-029 in_vec=40'h00_0000_0001 accepted, out_ready=1 -> 1 cycle later exactly one beat: index 0, seq 0, last=1; in_ready returns 1 on the next cycle.
REQ-030 in_vec=40'h80_0000_0024 accepted, out_ready=1 -> beats index 2, 5, 39 with seq 0, 1, 2; last=1 only on the index-39 beat.
REQ-031 in_vec=40'h00_0000_0300, out_ready low for 3 cycles on the first beat -> index 8 held stable for 3 cycles, then indices 8 and 9 each appear exactly once.
REQ-032 in_vec=40'hFF_FFFF_FFFF, rst pulsed after 4 handshakes -> outputs 0 and in_ready=1 immediately; no further beats after release.
REQ-033 in_vec=0 accepted -> with ZERO_FLAG_EN: one beat with index 0, last=1, none=1; without it: no out_valid and in_ready stays 1.
REQ-034 With in_valid held high and random vectors, out_ready random -> a scoreboard confirms each vector's set bits are reproduced exactly in ascending order, with no beat lost or duplicated.
